// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter blocks: FSM encoding, op codes,
// register bundles and their reset values.
package shift_pkg;

  localparam int SHIFT_W = 64;

  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_BUSY = 2'd1;
  localparam logic [1:0] SEQ_DONE = 2'd2;

  // Mode 3 is reserved and decodes as a left shift.
  localparam logic [1:0] MODE_SLL = 2'd0;
  localparam logic [1:0] MODE_SRL = 2'd1;
  localparam logic [1:0] MODE_SRA = 2'd2;

  typedef struct packed {
    logic [SHIFT_W-1:0] res;
    logic               valid;
  } Shifter_registers;

  typedef struct packed {
    logic [1:0]         state;
    logic [2:0]         k;
    logic [SHIFT_W-1:0] val;
    logic [1:0]         mode;
    logic               rv32;
    logic [5:0]         shamt;
    logic               fill;
  } ShiftSeq_registers;

  localparam ShiftSeq_registers ShiftSeq_r_reset = '{
    state: SEQ_IDLE,
    k:     3'd0,
    val:   '0,
    mode:  2'd0,
    rv32:  1'b0,
    shamt: 6'd0,
    fill:  1'b0
  };

endpackage

// File: rtl/shift_seq.sv
// Multi-cycle barrel shifter: one binary-weighted stage per BUSY cycle, so
// latency is fixed regardless of the shift amount.
//
// state | meaning
// IDLE  | waiting for a request, o_ready=1
// BUSY  | applying stage k (shift by 2^k when shamt[k]=1)
// DONE  | result strobe, o_valid=1; may accept the next request
module shift_seq
  import shift_pkg::*;
#(
  parameter int RISCV_ARCH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ena,
  input  logic [1:0]            i_mode,
  input  logic                  i_rv32,
  input  logic [RISCV_ARCH-1:0] i_a1,
  input  logic [5:0]            i_a2,
  input  logic                  i_flush,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [RISCV_ARCH-1:0] o_res
);

  ShiftSeq_registers r;
  ShiftSeq_registers rin;

  logic               ready;
  logic               accept;
  logic               stage_on;
  logic               right;
  logic [5:0]         step;
  logic [2:0]         last_k;
  logic [SHIFT_W-1:0] fill_mask;
  logic [SHIFT_W-1:0] staged;
  logic [SHIFT_W-1:0] working;

  always_comb begin
    ready     = (r.state == SEQ_IDLE) || (r.state == SEQ_DONE);
    accept    = i_ena & ready & ~i_flush;
    stage_on  = r.shamt[r.k];
    right     = (r.mode == MODE_SRL) || (r.mode == MODE_SRA);
    step      = 6'd1 << r.k;
    last_k    = r.rv32 ? 3'd4 : 3'd5;
    // Ones in the top 'step' bits: the positions vacated by a right shift.
    fill_mask = ~({SHIFT_W{1'b1}} >> step);

    if (!stage_on) begin
      staged = r.val;
    end else if (right) begin
      staged = (r.val >> step) | (r.fill ? fill_mask : '0);
    end else begin
      staged = r.val << step;
    end

    if (i_rv32 && i_mode == MODE_SRL) begin
      working = {32'd0, i_a1[31:0]};
    end else if (i_rv32 && i_mode == MODE_SRA) begin
      working = {{32{i_a1[31]}}, i_a1[31:0]};
    end else begin
      working = i_a1;
    end
  end

  always_comb begin
    rin = r;

    case (r.state)
      SEQ_IDLE: rin.state = SEQ_IDLE;
      SEQ_BUSY: begin
        rin.val = staged;
        if (r.k == last_k) begin
          rin.state = SEQ_DONE;
          rin.k     = 3'd0;
        end else begin
          rin.k = r.k + 3'd1;
        end
      end
      SEQ_DONE: rin.state = SEQ_IDLE;
      default:  rin.state = SEQ_IDLE;
    endcase

    if (accept) begin
      rin.state = SEQ_BUSY;
      rin.k     = 3'd0;
      rin.mode  = i_mode;
      rin.rv32  = i_rv32;
      rin.shamt = i_rv32 ? {1'b0, i_a2[4:0]} : i_a2;
      rin.fill  = (i_mode == MODE_SRA) & (i_rv32 ? i_a1[31] : i_a1[63]);
      rin.val   = working;
    end

    if (i_flush) begin
      rin.state = SEQ_IDLE;
      rin.k     = 3'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r <= ShiftSeq_r_reset;
    end else begin
      r <= rin;
    end
  end

  assign o_ready = ready;
  assign o_valid = (r.state == SEQ_DONE);
  assign o_res   = r.rv32 ? {{32{r.val[31]}}, r.val[31:0]} : r.val;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed corner cases plus randomized
// operations compared against an arithmetic shift reference.
module tb_shift_seq;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_ena;
  logic [1:0]  i_mode;
  logic        i_rv32;
  logic [63:0] i_a1;
  logic [5:0]  i_a2;
  logic        i_flush;
  logic        o_ready;
  logic        o_valid;
  logic [63:0] o_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  shift_seq #(.RISCV_ARCH(64)) dut (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_ena   (i_ena),
    .i_mode  (i_mode),
    .i_rv32  (i_rv32),
    .i_a1    (i_a1),
    .i_a2    (i_a2),
    .i_flush (i_flush),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_res   (o_res)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic [1:0] mode, input logic rv32,
                                            input logic [63:0] a1, input logic [5:0] a2);
    logic [31:0] w;
    logic [63:0] r;
    logic [4:0]  s;
    if (rv32) begin
      s = a2[4:0];
      case (mode)
        2'd1:    w = a1[31:0] >> s;
        2'd2:    w = $unsigned($signed(a1[31:0]) >>> s);
        default: w = a1[31:0] << s;
      endcase
      r = {{32{w[31]}}, w};
    end else begin
      case (mode)
        2'd1:    r = a1 >> a2;
        2'd2:    r = $unsigned($signed(a1) >>> a2);
        default: r = a1 << a2;
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Issues one request and returns in its DONE cycle.
  task automatic do_op(input string tag, input logic [1:0] mode, input logic rv32,
                       input logic [63:0] a1, input logic [5:0] a2);
    int lat;
    check($sformatf("%s_ready", tag), {63'd0, o_ready}, 64'd1);
    i_ena  = 1'b1;
    i_mode = mode;
    i_rv32 = rv32;
    i_a1   = a1;
    i_a2   = a2;
    step();
    i_ena  = 1'b0;
    i_mode = 2'($urandom);
    i_rv32 = 1'($urandom);
    i_a1   = {$urandom, $urandom};
    i_a2   = 6'($urandom);
    lat = 1;
    while (!o_valid && lat < 20) begin
      step();
      lat++;
    end
    check($sformatf("%s_lat", tag), 64'(lat), rv32 ? 64'd6 : 64'd7);
    check($sformatf("%s_res", tag), o_res, ref_shift(mode, rv32, a1, a2));
  endtask

  task automatic expect_no_valid(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (12) begin
      if (o_valid) seen = 1'b1;
      step();
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    i_nrst  = 1'b0;
    i_ena   = 1'b0;
    i_mode  = 2'd0;
    i_rv32  = 1'b0;
    i_a1    = '0;
    i_a2    = '0;
    i_flush = 1'b0;
    #2;
    check("rst_ready", {63'd0, o_ready}, 64'd1);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_res", o_res, 64'd0);
    step();
    step();
    i_nrst = 1'b1;
    step();

    do_op("sll63", 2'd0, 1'b0, 64'h1, 6'd63);
    check("sll63_val", o_res, 64'h8000_0000_0000_0000);
    step();
    check("strobe_one", {63'd0, o_valid}, 64'd0);
    do_op("sra4", 2'd2, 1'b0, 64'h8000_0000_0000_0000, 6'd4);
    check("sra4_val", o_res, 64'hF800_0000_0000_0000);
    step();
    do_op("sra0", 2'd2, 1'b0, 64'h8000_0000_0000_0000, 6'd0);
    check("sra0_val", o_res, 64'h8000_0000_0000_0000);
    step();
    do_op("srlw", 2'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'h3F);
    check("srlw_val", o_res, 64'h1);
    step();
    do_op("sraw", 2'd2, 1'b1, 64'h0000_0000_8000_0000, 6'd1);
    check("sraw_val", o_res, 64'hFFFF_FFFF_C000_0000);
    step();
    do_op("sllw", 2'd0, 1'b1, 64'h1, 6'd31);
    check("sllw_val", o_res, 64'hFFFF_FFFF_8000_0000);
    do_op("b2b_a", 2'd1, 1'b0, 64'hF0F0_0000_0000_1234, 6'd12);
    do_op("b2b_b", 2'd0, 1'b0, 64'h5, 6'd3);
    step();
    do_op("mode3", 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd17);
    step();
    do_op("w_zero", 2'd1, 1'b1, 64'h1234_5678_9ABC_DEF0, 6'd32);
    step();

    // Flush three cycles after accept.
    i_ena = 1'b1; i_mode = 2'd0; i_rv32 = 1'b0; i_a1 = 64'h1; i_a2 = 6'd1;
    step();
    i_ena = 1'b0;
    step();
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("flush_ready", {63'd0, o_ready}, 64'd1);
    expect_no_valid("flush_novalid");
    do_op("flush_new", 2'd0, 1'b0, 64'h3, 6'd2);
    check("flush_new_val", o_res, 64'hC);

    // Flush with a request in DONE: strobe stays, request is dropped.
    i_flush = 1'b1;
    i_ena = 1'b1; i_mode = 2'd0; i_rv32 = 1'b0; i_a1 = 64'h7; i_a2 = 6'd1;
    #1;
    check("flush_done_valid", {63'd0, o_valid}, 64'd1);
    step();
    i_flush = 1'b0;
    i_ena = 1'b0;
    check("flush_done_ready", {63'd0, o_ready}, 64'd1);
    expect_no_valid("flush_ena_dropped");

    // Reset two cycles after accept.
    i_ena = 1'b1; i_mode = 2'd2; i_rv32 = 1'b0; i_a1 = 64'hFFFF_0000_0000_0000; i_a2 = 6'd5;
    step();
    i_ena = 1'b0;
    step();
    i_nrst = 1'b0;
    #1;
    check("midrst_valid", {63'd0, o_valid}, 64'd0);
    check("midrst_ready", {63'd0, o_ready}, 64'd1);
    check("midrst_res", o_res, 64'd0);
    step();
    step();
    i_nrst = 1'b1;
    step();
    check("midrst_rel_ready", {63'd0, o_ready}, 64'd1);
    expect_no_valid("midrst_novalid");

    for (int i = 0; i < 60; i++) begin
      do_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 1'($urandom),
            {$urandom, $urandom}, 6'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
